// File: rtl/full_adder_pkg.sv
// Shared definitions for the full adder BIST: vector count, widths and FSM state encoding.
package full_adder_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;  // {A,B,Cin}
    localparam int unsigned ERR_W       = 4;  // holds 0..NUM_VECTORS

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_t;

endpackage

// File: rtl/full_adder_golden.sv
// Combinational reference full adder used by the BIST to judge the adder under test.
module full_adder_golden (
    input  logic i_A,
    input  logic i_B,
    input  logic i_Cin,
    output logic o_Sum,
    output logic o_Cout
);

    assign o_Sum  = i_A ^ i_B ^ i_Cin;
    assign o_Cout = (i_A & i_B) | (i_A & i_Cin) | (i_B & i_Cin);

endmodule

// File: rtl/full_adder_bist.sv
// Built-in self-test for an external 1-bit full adder: walks all 8 input vectors,
// compares the adder's outputs with a golden model and reports pass/fail status.
module full_adder_bist
    import full_adder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    output logic             o_A,
    output logic             o_B,
    output logic             o_Cin,
    input  logic             i_Sum,
    input  logic             i_Cout,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Pass,
    output logic [ERR_W-1:0] o_Err_Cnt,
    output logic [VEC_W-1:0] o_Fail_Vec
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VECTORS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [HOLD_W-1:0]  r_hold;
    logic [VEC_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [VEC_W-1:0]   r_fail_vec;

    logic               w_exp_sum;
    logic               w_exp_cout;
    logic               w_mismatch;
    logic               w_start_ok;
    logic               w_hold_last;
    logic               w_last_vec;

    full_adder_golden u_golden (
        .i_A    (r_idx[2]),
        .i_B    (r_idx[1]),
        .i_Cin  (r_idx[0]),
        .o_Sum  (w_exp_sum),
        .o_Cout (w_exp_cout)
    );

    // Start is only honoured when no run is in flight.
    assign w_start_ok  = i_Start && ((r_state == StIdle) || (r_state == StDone));
    assign w_hold_last = (r_hold == HOLD_LAST);
    assign w_last_vec  = (r_idx == LAST_VEC);
    assign w_mismatch  = ({i_Sum, i_Cout} != {w_exp_sum, w_exp_cout});

    // Next-state logic for the run sequencer.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_start_ok) w_state_next = StSettle;
            StSettle: if (w_hold_last) w_state_next = StCheck;
            StCheck:  w_state_next = w_last_vec ? StDone : StSettle;
            StDone:   if (w_start_ok) w_state_next = StSettle;
            default:  w_state_next = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Vector index, hold counter and status registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_hold     <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
        end else if (w_start_ok) begin
            r_hold     <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
        end else if (r_state == StSettle) begin
            r_hold <= w_hold_last ? '0 : r_hold + HOLD_W'(1);
        end else if (r_state == StCheck) begin
            if (w_mismatch) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
                if (r_err_cnt == '0) r_fail_vec <= r_idx;
            end
            // Busy drops as the last check completes; done follows once DONE is reached.
            if (w_last_vec) r_busy <= 1'b0;
            else            r_idx  <= r_idx + VEC_W'(1);
        end else if (r_state == StDone) begin
            r_done <= 1'b1;
            r_pass <= (r_err_cnt == '0);
        end
    end

    assign {o_A, o_B, o_Cin} = r_idx;
    assign o_Busy     = r_busy;
    assign o_Done     = r_done;
    assign o_Pass     = r_pass;
    assign o_Err_Cnt  = r_err_cnt;
    assign o_Fail_Vec = r_fail_vec;

endmodule

// File: tb/tb_full_adder_bist.sv
// Self-checking bench for full_adder_bist: an external adder with injectable per-vector
// faults, a behavioural expectation model and random fault/restart patterns.
module tb_full_adder_bist;

    localparam int unsigned H = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dut_a, dut_b, dut_cin;
    logic       sum, cout;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [2:0] fail_vec;

    // Per-vector flip masks applied by the external adder model.
    logic [7:0] f_sum;
    logic [7:0] f_cout;
    logic [2:0] cur_v;
    logic [1:0] tot;

    int total = 0;
    int bad   = 0;

    full_adder_bist #(.HOLD_CYCLES(H)) u_dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Start    (start),
        .o_A        (dut_a),
        .o_B        (dut_b),
        .o_Cin      (dut_cin),
        .i_Sum      (sum),
        .i_Cout     (cout),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Pass     (pass),
        .o_Err_Cnt  (err_cnt),
        .o_Fail_Vec (fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External adder under test: arithmetic sum of the three bits, optionally corrupted.
    always_comb begin
        cur_v = {dut_a, dut_b, dut_cin};
        tot   = 2'(dut_a) + 2'(dut_b) + 2'(dut_cin);
        sum   = tot[0] ^ f_sum[cur_v];
        cout  = tot[1] ^ f_cout[cur_v];
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},  int'({dut_a, dut_b, dut_cin}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"},  int'(err_cnt), 0);
        check({tag, "_fail"}, int'(fail_vec), 0);
    endtask

    // One complete run. Expected results come from counting faulty vectors directly.
    task automatic run_test(input string name, input logic [7:0] fs, input logic [7:0] fc,
                            input bit repulse);
        int busy_cnt;
        int done_at;
        int exp_err;
        int exp_fail;
        int exp_v;
        logic [7:0] any;
        any      = fs | fc;
        exp_err  = 0;
        exp_fail = -1;
        for (int v = 0; v < 8; v++) begin
            if (any[v]) begin
                exp_err++;
                if (exp_fail < 0) exp_fail = v;
            end
        end
        if (exp_fail < 0) exp_fail = 0;

        @(negedge clk);
        f_sum  = fs;
        f_cout = fc;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check({name, "_clr_busy"}, int'(busy), 1);
        check({name, "_clr_done"}, int'(done), 0);
        check({name, "_clr_pass"}, int'(pass), 0);
        check({name, "_clr_err"},  int'(err_cnt), 0);
        check({name, "_clr_fail"}, int'(fail_vec), 0);

        busy_cnt = 0;
        done_at  = -1;
        for (int n = 0; n < 40; n++) begin
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = n;
            exp_v = (n < 8 * (H + 1)) ? n / (H + 1) : 7;
            check({name, "_vec"}, int'({dut_a, dut_b, dut_cin}), exp_v);
            start = repulse && (n == 4);
            if (done_at >= 0) break;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done_at"},  done_at, 8 * (H + 1) + 1);
        check({name, "_busy_len"}, busy_cnt, 8 * (H + 1));
        check({name, "_err"},      int'(err_cnt), exp_err);
        check({name, "_fail"},     int'(fail_vec), exp_fail);
        check({name, "_pass"},     int'(pass), (exp_err == 0) ? 1 : 0);
        // Status must hold while idling in DONE.
        repeat (3) @(negedge clk);
        check({name, "_hold_done"}, int'(done), 1);
        check({name, "_hold_err"},  int'(err_cnt), exp_err);
    endtask

    initial begin
        logic [7:0] stuck_cout;
        rst    = 1'b1;
        start  = 1'b0;
        f_sum  = 8'h00;
        f_cout = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Good adder, then cout stuck at 0, then inverted sum.
        run_test("good", 8'h00, 8'h00, 1'b0);
        stuck_cout = 8'h00;
        for (int v = 0; v < 8; v++) begin
            if (((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1) >= 2) stuck_cout[v] = 1'b1;
        end
        run_test("cout0", 8'h00, stuck_cout, 1'b0);
        check("cout0_err_const",  int'(err_cnt), 4);
        check("cout0_fail_const", int'(fail_vec), 3);
        run_test("suminv", 8'hFF, 8'h00, 1'b0);
        check("suminv_err_const", int'(err_cnt), 8);

        // Start in DONE after a failing run: cleared on that edge, then passes.
        run_test("restart", 8'h00, 8'h00, 1'b0);
        check("restart_pass", int'(pass), 1);

        // Re-pulsed start during a run is ignored.
        run_test("repulse", 8'h00, 8'h00, 1'b1);

        // Reset 10 cycles into a failing run.
        @(negedge clk);
        f_sum = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        run_test("after_abort", 8'h00, 8'h00, 1'b0);

        // Random fault patterns with occasional ignored restarts.
        for (int r = 0; r < 8; r++) begin
            run_test($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
